// File: rtl/hf_mode_sequencer_pkg.sv
// Shared HF FPGA definitions: command opcodes, major-mode encodings and
// the sequencer state type.
package hf_mode_sequencer_pkg;

  localparam logic [3:0] FPGA_CMD_SET_CONFREG  = 4'h1;
  localparam logic [3:0] FPGA_CMD_TRACE_ENABLE = 4'h2;

  typedef enum logic [2:0] {
    MM_READER    = 3'd0,
    MM_SIMULATOR = 3'd1,
    MM_ISO14443A = 3'd2,
    MM_SNIFF     = 3'd3,
    MM_ISO18092  = 3'd4,
    MM_GET_TRACE = 3'd5,
    MM_OFF       = 3'd7
  } major_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_SETTLE = 2'd2
  } seq_state_e;

endpackage

// File: rtl/hf_guard_timer.sv
// Loadable 8-bit interval counter with a terminal-count flag; times both
// the pre-switch guard and the post-switch settle intervals.
module hf_guard_timer (
  input  logic       clk,
  input  logic       nreset,
  input  logic       clear,
  input  logic       en,
  input  logic [7:0] limit,
  output logic       tc
);

  logic [7:0] count_q;
  logic [7:0] count_d;

  // Clear wins over count so an interval boundary restarts at zero.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = 8'd0;
    end else if (en && (count_q != limit)) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == limit);

endmodule

// File: rtl/hf_mode_sequencer.sv
// Applies HF configuration commands; major-mode changes quiesce the coil
// drivers for a guard interval before and a settle interval after the switch.
module hf_mode_sequencer
  import hf_mode_sequencer_pkg::*;
#(
  parameter int unsigned GUARD_CYCLES  = 16,
  parameter int unsigned SETTLE_CYCLES = 8
) (
  input  logic        ck_1356meg,
  input  logic        nreset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_word,
  output logic [2:0]  major_mode,
  output logic [3:0]  minor_mode,
  output logic [1:0]  subcarrier_frequency,
  output logic        trace_enable,
  output logic        pwr_quiesce,
  output logic        switch_done
);

  localparam logic [7:0] GUARD_LAST  = 8'(GUARD_CYCLES - 1);
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  seq_state_e state_q, state_d;
  logic [2:0] major_q, major_d, pend_major_q, pend_major_d;
  logic [3:0] minor_q, minor_d, pend_minor_q, pend_minor_d;
  logic [1:0] sub_q, sub_d, pend_sub_q, pend_sub_d;
  logic       trace_q, trace_d;
  logic       quiesce_q, quiesce_d;
  logic       done_q, done_d;
  logic       ready_q, ready_d;

  logic       transfer;
  logic [3:0] opcode;
  logic       timer_clear, timer_en, timer_tc;
  logic [7:0] timer_limit;
  logic       unused_word_bits;

  assign transfer         = cmd_valid & ready_q;
  assign opcode           = cmd_word[15:12];
  assign unused_word_bits = ^cmd_word[11:9];

  always_comb begin
    state_d      = state_q;
    major_d      = major_q;
    minor_d      = minor_q;
    sub_d        = sub_q;
    trace_d      = trace_q;
    quiesce_d    = quiesce_q;
    ready_d      = ready_q;
    done_d       = 1'b0;
    pend_major_d = pend_major_q;
    pend_minor_d = pend_minor_q;
    pend_sub_d   = pend_sub_q;
    timer_clear  = 1'b0;
    timer_en     = 1'b0;
    timer_limit  = GUARD_LAST;

    unique case (state_q)
      ST_IDLE: begin
        ready_d = 1'b1;
        if (transfer) begin
          case (opcode)
            FPGA_CMD_SET_CONFREG: begin
              if (cmd_word[8:6] == major_q) begin
                minor_d = cmd_word[3:0];
                sub_d   = cmd_word[5:4];
                done_d  = 1'b1;
              end else begin
                pend_major_d = cmd_word[8:6];
                pend_sub_d   = cmd_word[5:4];
                pend_minor_d = cmd_word[3:0];
                quiesce_d    = 1'b1;
                ready_d      = 1'b0;
                timer_clear  = 1'b1;
                state_d      = ST_DRAIN;
              end
            end
            FPGA_CMD_TRACE_ENABLE: begin
              trace_d = cmd_word[0];
              done_d  = 1'b1;
            end
            default: ;
          endcase
        end
      end
      ST_DRAIN: begin
        timer_en    = 1'b1;
        timer_limit = GUARD_LAST;
        if (timer_tc) begin
          major_d     = pend_major_q;
          minor_d     = pend_minor_q;
          sub_d       = pend_sub_q;
          timer_clear = 1'b1;
          state_d     = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        timer_en    = 1'b1;
        timer_limit = SETTLE_LAST;
        if (timer_tc) begin
          quiesce_d   = 1'b0;
          ready_d     = 1'b1;
          done_d      = 1'b1;
          timer_clear = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ck_1356meg) begin
    if (!nreset) begin
      state_q      <= ST_IDLE;
      major_q      <= MM_OFF;
      minor_q      <= 4'd0;
      sub_q        <= 2'd0;
      trace_q      <= 1'b0;
      quiesce_q    <= 1'b0;
      done_q       <= 1'b0;
      ready_q      <= 1'b0;
      pend_major_q <= MM_OFF;
      pend_minor_q <= 4'd0;
      pend_sub_q   <= 2'd0;
    end else begin
      state_q      <= state_d;
      major_q      <= major_d;
      minor_q      <= minor_d;
      sub_q        <= sub_d;
      trace_q      <= trace_d;
      quiesce_q    <= quiesce_d;
      done_q       <= done_d;
      ready_q      <= ready_d;
      pend_major_q <= pend_major_d;
      pend_minor_q <= pend_minor_d;
      pend_sub_q   <= pend_sub_d;
    end
  end

  hf_guard_timer u_guard_timer (
    .clk    (ck_1356meg),
    .nreset (nreset),
    .clear  (timer_clear),
    .en     (timer_en),
    .limit  (timer_limit),
    .tc     (timer_tc)
  );

  assign cmd_ready            = ready_q;
  assign major_mode           = major_q;
  assign minor_mode           = minor_q;
  assign subcarrier_frequency = sub_q;
  assign trace_enable         = trace_q;
  assign pwr_quiesce          = quiesce_q;
  assign switch_done          = done_q;

endmodule

// File: tb/tb_hf_mode_sequencer.sv
// Self-checking bench for hf_mode_sequencer: vector table for single-cycle
// commands plus hand-written major-switch, back-pressure and reset sequences.
module tb_hf_mode_sequencer;

  localparam int G = 16;
  localparam int S = 8;

  typedef struct packed {
    logic [2:0] major;
    logic [3:0] minor;
    logic [1:0] sub;
    logic       trace;
    logic       quiesce;
    logic       done;
    logic       ready;
  } out_t;

  typedef struct packed {
    logic        valid;
    logic [15:0] word;
    out_t        exp;
  } vec_t;

  logic        ck_1356meg = 1'b0;
  logic        nreset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_word;
  logic [2:0]  major_mode;
  logic [3:0]  minor_mode;
  logic [1:0]  subcarrier_frequency;
  logic        trace_enable;
  logic        pwr_quiesce;
  logic        switch_done;

  int   n_checks = 0;
  int   n_fail   = 0;
  out_t sb[$];
  out_t cur;
  string label;

  always #5 ck_1356meg = ~ck_1356meg;

  hf_mode_sequencer #(
    .GUARD_CYCLES  (G),
    .SETTLE_CYCLES (S)
  ) dut (
    .ck_1356meg           (ck_1356meg),
    .nreset               (nreset),
    .cmd_valid            (cmd_valid),
    .cmd_ready            (cmd_ready),
    .cmd_word             (cmd_word),
    .major_mode           (major_mode),
    .minor_mode           (minor_mode),
    .subcarrier_frequency (subcarrier_frequency),
    .trace_enable         (trace_enable),
    .pwr_quiesce          (pwr_quiesce),
    .switch_done          (switch_done)
  );

  function automatic out_t mkOut(input logic [2:0] ma, input logic [3:0] mi,
                                 input logic [1:0] su, input logic tr,
                                 input logic q, input logic d, input logic r);
    out_t o;
    o.major = ma; o.minor = mi; o.sub = su; o.trace = tr;
    o.quiesce = q; o.done = d; o.ready = r;
    return o;
  endfunction

  task automatic cmpField(input string f, input logic [3:0] act, input logic [3:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s.%s: actual %0h required %0h at %0t", label, f, act, req, $time);
    end
  endtask

  task automatic checkOutput();
    out_t e;
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("[TB] FAIL %s.scoreboard: actual empty required entry", label);
    end else begin
      e = sb.pop_front();
      cmpField("major",   {1'b0, major_mode},           {1'b0, e.major});
      cmpField("minor",   minor_mode,                   e.minor);
      cmpField("sub",     {2'b0, subcarrier_frequency}, {2'b0, e.sub});
      cmpField("trace",   {3'b0, trace_enable},         {3'b0, e.trace});
      cmpField("quiesce", {3'b0, pwr_quiesce},          {3'b0, e.quiesce});
      cmpField("done",    {3'b0, switch_done},          {3'b0, e.done});
      cmpField("ready",   {3'b0, cmd_ready},            {3'b0, e.ready});
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [15:0] w, input out_t e);
    cmd_valid = v;
    cmd_word  = w;
    sb.push_back(e);
    @(posedge ck_1356meg);
    #1;
    checkOutput();
  endtask

  task automatic runMajorChange(input logic [15:0] w, input logic [2:0] nmaj,
                                input logic [1:0] nsub, input logic [3:0] nmin);
    out_t e;
    e = cur;
    e.quiesce = 1'b1; e.done = 1'b0; e.ready = 1'b0;
    applyStimulus(1'b1, w, e);
    for (int j = 1; j <= G + S; j++) begin
      e = cur;
      if (j >= G) begin
        e.major = nmaj; e.minor = nmin; e.sub = nsub;
      end
      e.quiesce = (j < G + S);
      e.done    = (j == G + S);
      e.ready   = (j == G + S);
      applyStimulus(1'b0, 16'h0000, e);
    end
    cur = mkOut(nmaj, nmin, nsub, cur.trace, 1'b0, 1'b0, 1'b1);
  endtask

  vec_t vecs[10];

  initial begin
    out_t e;
    nreset    = 1'b0;
    cmd_valid = 1'b0;
    cmd_word  = 16'h0000;

    label = "reset";
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 16'h0000, mkOut(3'd7, 4'd0, 2'd0, 0, 0, 0, 0));
    nreset = 1'b1;
    label = "release";
    applyStimulus(1'b0, 16'h0000, mkOut(3'd7, 4'd0, 2'd0, 0, 0, 0, 1));
    cur = mkOut(3'd7, 4'd0, 2'd0, 0, 0, 0, 1);

    label = "major_off_to_1";
    runMajorChange(16'h1045, 3'd1, 2'd0, 4'd5);

    vecs[0] = '{1'b1, 16'h1043, mkOut(3'd1, 4'd3, 2'd0, 0, 0, 1, 1)};
    vecs[1] = '{1'b1, 16'h1063, mkOut(3'd1, 4'd3, 2'd2, 0, 0, 1, 1)};
    vecs[2] = '{1'b1, 16'h2001, mkOut(3'd1, 4'd3, 2'd2, 1, 0, 1, 1)};
    vecs[3] = '{1'b1, 16'hF1FF, mkOut(3'd1, 4'd3, 2'd2, 1, 0, 0, 1)};
    vecs[4] = '{1'b0, 16'h1000, mkOut(3'd1, 4'd3, 2'd2, 1, 0, 0, 1)};
    vecs[5] = '{1'b1, 16'h0040, mkOut(3'd1, 4'd3, 2'd2, 1, 0, 0, 1)};
    vecs[6] = '{1'b1, 16'h2000, mkOut(3'd1, 4'd3, 2'd2, 0, 0, 1, 1)};
    vecs[7] = '{1'b1, 16'h1045, mkOut(3'd1, 4'd5, 2'd0, 0, 0, 1, 1)};
    vecs[8] = '{1'b1, 16'h1058, mkOut(3'd1, 4'd8, 2'd1, 0, 0, 1, 1)};
    vecs[9] = '{1'b1, 16'h1045, mkOut(3'd1, 4'd5, 2'd0, 0, 0, 1, 1)};
    for (int i = 0; i < 10; i++) begin
      label = $sformatf("vec%0d", i);
      applyStimulus(vecs[i].valid, vecs[i].word, vecs[i].exp);
    end
    cur = mkOut(3'd1, 4'd5, 2'd0, 0, 0, 0, 1);

    label = "backpressure";
    applyStimulus(1'b1, 16'h1080, mkOut(3'd1, 4'd5, 2'd0, 0, 1, 0, 0));
    for (int j = 1; j <= G + S; j++) begin
      e = (j >= G) ? mkOut(3'd2, 4'd0, 2'd0, 0, 1, 0, 0) : mkOut(3'd1, 4'd5, 2'd0, 0, 1, 0, 0);
      e.quiesce = (j < G + S);
      e.done    = (j == G + S);
      e.ready   = (j == G + S);
      applyStimulus(1'b1, 16'h2001, e);
    end
    label = "backpressure_trace";
    applyStimulus(1'b1, 16'h2001, mkOut(3'd2, 4'd0, 2'd0, 1, 0, 1, 1));
    applyStimulus(1'b0, 16'h0000, mkOut(3'd2, 4'd0, 2'd0, 1, 0, 0, 1));
    cur = mkOut(3'd2, 4'd0, 2'd0, 1, 0, 0, 1);

    label = "major_2_to_off";
    runMajorChange(16'h11C5, 3'd7, 2'd0, 4'd5);

    label = "same_major_off";
    applyStimulus(1'b1, 16'h11C3, mkOut(3'd7, 4'd3, 2'd0, 1, 0, 1, 1));
    applyStimulus(1'b0, 16'h0000, mkOut(3'd7, 4'd3, 2'd0, 1, 0, 0, 1));

    label = "reset_mid_drain";
    applyStimulus(1'b1, 16'h1040, mkOut(3'd7, 4'd3, 2'd0, 1, 1, 0, 0));
    for (int j = 1; j <= 5; j++) applyStimulus(1'b0, 16'h0000, mkOut(3'd7, 4'd3, 2'd0, 1, 1, 0, 0));
    nreset = 1'b0;
    applyStimulus(1'b0, 16'h0000, mkOut(3'd7, 4'd0, 2'd0, 0, 0, 0, 0));
    nreset = 1'b1;
    label = "after_abort";
    for (int j = 0; j < G + S + 2; j++) applyStimulus(1'b0, 16'h0000, mkOut(3'd7, 4'd0, 2'd0, 0, 0, 0, 1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
